// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar egress arbiter.
// Holds the AXI-Stream geometry used on every point and on the egress port,
// the default point count and the arbiter state encoding.
package crossbar_pkg;

   localparam int AXIS_DATA_W = 64;
   localparam int AXIS_KEEP_W = 8;
   localparam int AXIS_DEST_W = 3;
   localparam int DEF_PORTS   = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BUSY  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
// Finds the first set request bit starting at ptr and searching upward,
// wrapping from P_PORTS-1 back to 0.
//   req   : request vector, one bit per point
//   ptr   : starting index of the search (highest priority this round)
//   found : at least one request bit is set
//   idx   : index of the winning request (0 when none)
module rr_pick #(
   parameter int P_PORTS = 8,
   parameter int P_IDX_W = 3
) (
   input  logic [P_PORTS-1:0] req,
   input  logic [P_IDX_W-1:0] ptr,
   output logic               found,
   output logic [P_IDX_W-1:0] idx
);

   always_comb begin
      int                 cand;
      logic [P_IDX_W-1:0] cand_idx;
      cand     = 0;
      cand_idx = '0;
      found    = 1'b0;
      idx      = '0;
      for (int i = 0; i < P_PORTS; i++) begin
         // Explicit wrap keeps the search correct when P_PORTS is not a power of 2.
         cand = int'(ptr) + i;
         if (cand >= P_PORTS) begin
            cand = cand - P_PORTS;
         end
         cand_idx = P_IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found = 1'b1;
            idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/crossbar_arbiter.sv
// Output-side arbiter for one crossbar egress port.
// Samples per-point transmit requests in IDLE, issues a one-cycle registered
// grant pulse in round-robin order, then steers the granted point's
// AXI-Stream onto the egress port until its tlast handshake. A watchdog
// releases the port if the granted point never presents data.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_trans_req      : per-point transmit request (level)
//   o_trans_grant    : one-hot, single-cycle grant pulse
//   s_axis_*         : per-point AXI-Stream slaves (point k in slice k)
//   m_axis_*         : egress AXI-Stream master (tuser tied 0)
//   o_busy           : arbiter is granting or serving a packet
//   o_timeout        : one-cycle pulse when the watchdog aborts a service
module crossbar_arbiter
   import crossbar_pkg::*;
#(
   parameter int P_PORTS   = DEF_PORTS,
   parameter int P_TIMEOUT = 1024,
   parameter int P_IDX_W   = 3
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [P_PORTS-1:0]             i_trans_req,
   output logic [P_PORTS-1:0]             o_trans_grant,
   input  logic [P_PORTS-1:0]             s_axis_tvalid,
   input  logic [AXIS_DATA_W*P_PORTS-1:0] s_axis_tdata,
   input  logic [P_PORTS-1:0]             s_axis_tlast,
   input  logic [AXIS_KEEP_W*P_PORTS-1:0] s_axis_tkeep,
   output logic [P_PORTS-1:0]             s_axis_tready,
   output logic                           m_axis_tvalid,
   output logic [AXIS_DATA_W-1:0]         m_axis_tdata,
   output logic                           m_axis_tlast,
   output logic [AXIS_KEEP_W-1:0]         m_axis_tkeep,
   output logic                           m_axis_tuser,
   input  logic                           m_axis_tready,
   output logic                           o_busy,
   output logic                           o_timeout
);

   localparam int              WD_W    = $clog2(P_TIMEOUT) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(P_TIMEOUT - 1);

   function automatic logic [P_IDX_W-1:0] next_idx(input logic [P_IDX_W-1:0] cur);
      if (int'(cur) >= P_PORTS - 1) begin
         return '0;
      end
      return cur + P_IDX_W'(1);
   endfunction

   function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] cur);
      if (&cur) begin
         return cur;
      end
      return cur + WD_W'(1);
   endfunction

   arb_state_e         state, state_nxt;
   logic [P_IDX_W-1:0] sel, sel_nxt;
   logic [P_IDX_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [WD_W-1:0]    wdog, wdog_nxt;
   logic               seen, seen_nxt;
   logic [P_PORTS-1:0] grant_nxt;
   logic               pick_found;
   logic [P_IDX_W-1:0] pick_idx;
   logic               pkt_done;
   logic               wd_abort;

   rr_pick #(
      .P_PORTS (P_PORTS),
      .P_IDX_W (P_IDX_W)
   ) u_rr_pick (
      .req   (i_trans_req),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // ---- zero-latency egress mux, live only while serving a packet ----
   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tkeep  = '0;
      s_axis_tready = '0;
      if (state == ST_BUSY) begin
         for (int k = 0; k < P_PORTS; k++) begin
            if (sel == P_IDX_W'(k)) begin
               m_axis_tvalid    = s_axis_tvalid[k];
               m_axis_tdata     = s_axis_tdata[k*AXIS_DATA_W +: AXIS_DATA_W];
               m_axis_tlast     = s_axis_tlast[k];
               m_axis_tkeep     = s_axis_tkeep[k*AXIS_KEEP_W +: AXIS_KEEP_W];
               s_axis_tready[k] = m_axis_tready;
            end
         end
      end
   end

   assign m_axis_tuser = 1'b0;
   assign o_busy       = (state != ST_IDLE);
   assign pkt_done     = (state == ST_BUSY) && m_axis_tvalid && m_axis_tready && m_axis_tlast;
   // The watchdog only matters until the first valid beat; after that the
   // point owns the port for as long as backpressure lasts.
   assign wd_abort     = (state == ST_BUSY) && !seen && !m_axis_tvalid && (wdog == WD_LAST);
   assign o_timeout    = wd_abort;

   // ---- next-state: arbitration, service tracking, watchdog ----
   always_comb begin
      state_nxt  = state;
      sel_nxt    = sel;
      rr_ptr_nxt = rr_ptr;
      wdog_nxt   = wdog;
      seen_nxt   = seen;
      grant_nxt  = '0;
      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               sel_nxt             = pick_idx;
               grant_nxt[pick_idx] = 1'b1;
               state_nxt           = ST_GRANT;
            end
         end
         ST_GRANT: begin
            wdog_nxt  = '0;
            seen_nxt  = 1'b0;
            state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            if (pkt_done || wd_abort) begin
               rr_ptr_nxt = next_idx(sel);
               state_nxt  = ST_IDLE;
            end else if (!seen) begin
               if (m_axis_tvalid) begin
                  seen_nxt = 1'b1;
               end else begin
                  wdog_nxt = wd_sat_inc(wdog);
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---- state registers ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= ST_IDLE;
         sel           <= '0;
         rr_ptr        <= '0;
         wdog          <= '0;
         seen          <= 1'b0;
         o_trans_grant <= '0;
      end else begin
         state         <= state_nxt;
         sel           <= sel_nxt;
         rr_ptr        <= rr_ptr_nxt;
         wdog          <= wdog_nxt;
         seen          <= seen_nxt;
         o_trans_grant <= grant_nxt;
      end
   end

endmodule

// File: tb/tb_crossbar_arbiter.sv
module tb_crossbar_arbiter;
   import crossbar_pkg::*;

   localparam int P  = 8;
   localparam int TO = 16;
   localparam int IW = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [P-1:0]    req_r, gnt, tvalid_r, tlast_r, tready_s;
   logic [64*P-1:0] tdata_r;
   logic [8*P-1:0]  tkeep_r;
   logic            mv, ml, mu, m_tready, busy, tmo;
   logic [63:0]     md;
   logic [7:0]      mk;

   crossbar_arbiter #(.P_PORTS(P), .P_TIMEOUT(TO), .P_IDX_W(IW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_trans_req(req_r), .o_trans_grant(gnt),
      .s_axis_tvalid(tvalid_r), .s_axis_tdata(tdata_r), .s_axis_tlast(tlast_r),
      .s_axis_tkeep(tkeep_r), .s_axis_tready(tready_s),
      .m_axis_tvalid(mv), .m_axis_tdata(md), .m_axis_tlast(ml), .m_axis_tkeep(mk),
      .m_axis_tuser(mu), .m_axis_tready(m_tready), .o_busy(busy), .o_timeout(tmo));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Point sources: main posts packets, the source process owns the point wires.
   int       posted[P];
   int       taken[P];
   int       rem[P];
   int       beat[P];
   int       len_cmd[P];
   logic [7:0] keep_cmd[P];
   bit       silent_cmd[P];

   initial begin
      logic [P-1:0] hs, gr;
      bit rs;
      req_r = '0; tvalid_r = '0; tdata_r = '0; tlast_r = '0; tkeep_r = '0;
      forever begin
         @(posedge clk);
         hs = tready_s & tvalid_r;
         gr = gnt;
         rs = !rst_n;
         #1;
         for (int k = 0; k < P; k++) begin
            if (rs) begin
               taken[k] = posted[k];
               rem[k]   = 0;
            end else begin
               if (hs[k] && rem[k] > 0) begin rem[k]--; beat[k]++; end
               if (gr[k]) begin taken[k]++; rem[k] = len_cmd[k]; beat[k] = 0; end
            end
            req_r[k]            = posted[k] > taken[k];
            tvalid_r[k]         = rem[k] > 0 && !silent_cmd[k];
            tdata_r[k*64 +: 64] = {8'(k), 24'(taken[k]), 32'(beat[k])};
            tlast_r[k]          = rem[k] == 1;
            tkeep_r[k*8 +: 8]   = (rem[k] == 1) ? keep_cmd[k] : 8'hFF;
         end
      end
   end

   // Reference model: who owns the port and what it must look like.
   int m_ptr = 0, m_owner = 0, m_wait = 0;
   bit m_granting = 0, m_serving = 0, m_seen = 0;

   function automatic int rr_find(input logic [P-1:0] r, input int ptr);
      for (int j = 0; j < P; j++) if (r[(ptr + j) % P]) return (ptr + j) % P;
      return -1;
   endfunction

   initial begin
      int f;
      bit v;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_ptr = 0; m_owner = 0; m_wait = 0; m_granting = 0; m_serving = 0; m_seen = 0;
         end else if (m_serving) begin
            v = tvalid_r[m_owner];
            if (v && m_tready && tlast_r[m_owner]) begin
               m_serving = 0; m_ptr = (m_owner + 1) % P;
            end else if (!m_seen && !v && m_wait == TO - 1) begin
               m_serving = 0; m_ptr = (m_owner + 1) % P;
            end else if (!m_seen) begin
               if (v) m_seen = 1; else m_wait++;
            end
         end else if (m_granting) begin
            m_granting = 0; m_serving = 1; m_seen = 0; m_wait = 0;
         end else begin
            f = rr_find(req_r, m_ptr);
            if (f >= 0) begin m_owner = f; m_granting = 1; end
         end
      end
   end

   typedef struct { int cyc; int idx; } g_rec_t;
   typedef struct { int cyc; logic [63:0] d; logic l; logic [7:0] k; } b_rec_t;
   g_rec_t gq[$];
   b_rec_t bq[$];
   int     tq[$];

   // Per-cycle compare against the model, plus event logging.
   initial begin
      logic [P-1:0] eg, etr;
      logic [63:0]  ed;
      logic         ev, el, et;
      logic [7:0]   ek;
      forever begin
         @(negedge clk);
         eg = '0; etr = '0; ed = '0; ev = 0; el = 0; ek = '0; et = 0;
         if (m_granting) eg[m_owner] = 1'b1;
         if (m_serving) begin
            etr[m_owner] = m_tready;
            ev = tvalid_r[m_owner];
            ed = tdata_r[m_owner*64 +: 64];
            el = tlast_r[m_owner];
            ek = tkeep_r[m_owner*8 +: 8];
            et = !m_seen && !tvalid_r[m_owner] && (m_wait == TO - 1);
         end
         chk("grant", gnt, eg);
         chk("s_tready", tready_s, etr);
         chk("m_tvalid", mv, ev);
         chk("m_tdata", md, ed);
         chk("m_tlast", ml, el);
         chk("m_tkeep", mk, ek);
         chk("m_tuser", mu, 0);
         chk("busy", busy, m_granting | m_serving);
         chk("timeout", tmo, et);
         for (int k = 0; k < P; k++) if (gnt[k]) gq.push_back('{cyc, k});
         if (mv && m_tready) bq.push_back('{cyc, md, ml, mk});
         if (tmo) tq.push_back(cyc);
      end
   end

   task automatic post(input int k, input int len, input logic [7:0] keep, input bit sil);
      len_cmd[k] = len; keep_cmd[k] = keep; silent_cmd[k] = sil; posted[k]++;
   endtask

   task automatic do_reset();
      @(posedge clk); #3 rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic wait_grants(input int target, input int budget);
      int n = 0;
      while (gq.size() < target && n < budget) begin @(negedge clk); #1; n++; end
      chk("wait_grants", gq.size() >= target, 1);
   endtask

   task automatic wait_beats(input int target, input int budget);
      int n = 0;
      while (bq.size() < target && n < budget) begin @(negedge clk); #1; n++; end
      chk("wait_beats", bq.size() >= target, 1);
   endtask

   task automatic wait_tmo(input int target, input int budget);
      int n = 0;
      while (tq.size() < target && n < budget) begin @(negedge clk); #1; n++; end
      chk("wait_timeout", tq.size() >= target, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      int pc, g0, g1, b0, t0, gc;
      m_tready = 1'b1;
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_grant", gnt, 0);
      chk("rst_tready", tready_s, 0);
      chk("rst_mvalid", mv, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", tmo, 0);
      @(posedge clk); #1 rst_n = 1;

      // T1: single 4-beat packet from point 2
      @(negedge clk); #1;
      pc = cyc; g0 = gq.size(); b0 = bq.size();
      post(2, 4, 8'h3F, 0);
      wait_grants(g0 + 1, 20);
      if (gq.size() > g0) begin
         chk("t1_gidx", gq[g0].idx, 2);
         chk("t1_gcyc", gq[g0].cyc, pc + 2);
      end
      wait_beats(b0 + 4, 40);
      if (bq.size() >= b0 + 4) begin
         for (int j = 0; j < 4; j++) begin
            chk("t1_last", bq[b0+j].l, j == 3);
            chk("t1_beat", bq[b0+j].d[31:0], j);
            chk("t1_src", bq[b0+j].d[63:56], 2);
         end
         chk("t1_keep", bq[b0+3].k, 8'h3F);
      end
      chk("t1_busy_at_last", busy, 1);
      @(negedge clk); #1;
      chk("t1_busy_after", busy, 0);

      // T2: all points request, 2-beat packets, point 0 twice
      do_reset();
      @(negedge clk); #1;
      g0 = gq.size(); b0 = bq.size();
      for (int k = 0; k < P; k++) post(k, 2, 8'hFF, 0);
      post(0, 2, 8'hFF, 0);
      wait_grants(g0 + 9, 200);
      wait_beats(b0 + 18, 200);
      if (gq.size() >= g0 + 9 && bq.size() >= b0 + 18) begin
         for (int i = 0; i < 9; i++) begin
            chk("t2_order", gq[g0+i].idx, (i == 8) ? 0 : i);
            chk("t2_src", bq[b0+2*i].d[63:56], (i == 8) ? 0 : i);
         end
         for (int i = 0; i < 8; i++)
            chk("t2_gap", bq[b0+2*i+2].cyc - bq[b0+2*i+1].cyc, 3);
      end

      // T3: backpressure 1,0,0,1 on a 3-beat packet from point 5
      do_reset();
      @(negedge clk); #1;
      g0 = gq.size(); b0 = bq.size();
      post(5, 3, 8'hFF, 0);
      wait_grants(g0 + 1, 20);
      @(posedge clk); #1 m_tready = 1;
      @(posedge clk); #1 m_tready = 0;
      @(negedge clk);
      chk("t3_stall_tready", tready_s, 0);
      chk("t3_stall_valid", mv, 1);
      @(posedge clk); #1 m_tready = 0;
      @(posedge clk); #1 m_tready = 1;
      @(negedge clk);
      chk("t3_resume_tready", tready_s, 8'h20);
      wait_beats(b0 + 3, 20);
      if (bq.size() >= b0 + 3) begin
         for (int j = 0; j < 3; j++) begin
            chk("t3_beat", bq[b0+j].d[31:0], j);
            chk("t3_last", bq[b0+j].l, j == 2);
         end
         chk("t3_cyc1", bq[b0+1].cyc - bq[b0].cyc, 3);
         chk("t3_cyc2", bq[b0+2].cyc - bq[b0].cyc, 4);
      end
      repeat (3) @(negedge clk);
      chk("t3_no_extra", bq.size(), b0 + 3);

      // T4: watchdog abort on point 1, then point 3 served
      do_reset();
      @(negedge clk); #1;
      g0 = gq.size(); b0 = bq.size(); t0 = tq.size();
      post(1, 2, 8'hFF, 1);
      post(3, 2, 8'hFF, 0);
      wait_grants(g0 + 1, 20);
      gc = (gq.size() > g0) ? gq[g0].cyc : 0;
      if (gq.size() > g0) chk("t4_first", gq[g0].idx, 1);
      wait_tmo(t0 + 1, 40);
      if (tq.size() > t0) chk("t4_tmo_cyc", tq[t0], gc + 16);
      wait_grants(g0 + 2, 20);
      if (gq.size() > g0 + 1) begin
         chk("t4_next", gq[g0+1].idx, 3);
         chk("t4_next_cyc", gq[g0+1].cyc, gc + 18);
      end
      wait_beats(b0 + 2, 20);
      if (bq.size() > b0) chk("t4_src", bq[b0].d[63:56], 3);

      // T5: 1-beat packet from point 7, pointer wraps to 0
      do_reset();
      @(negedge clk); #1;
      g0 = gq.size(); b0 = bq.size();
      post(7, 1, 8'h0F, 0);
      wait_beats(b0 + 1, 20);
      if (bq.size() > b0) begin
         chk("t5_last", bq[b0].l, 1);
         chk("t5_keep", bq[b0].k, 8'h0F);
         chk("t5_src", bq[b0].d[63:56], 7);
      end
      repeat (2) @(negedge clk);
      #1 g1 = gq.size();
      post(6, 1, 8'hFF, 0);
      post(0, 1, 8'hFF, 0);
      wait_grants(g1 + 2, 30);
      if (gq.size() >= g1 + 2) begin
         chk("t5_wrap", gq[g1].idx, 0);
         chk("t5_then", gq[g1+1].idx, 6);
      end

      // T6: async reset mid-packet, then a normal grant
      do_reset();
      @(negedge clk); #1;
      b0 = bq.size();
      post(2, 6, 8'hFF, 0);
      wait_beats(b0 + 2, 20);
      chk("t6_pre_valid", mv, 1);
      #2 rst_n = 0;
      #1;
      chk("t6_async_valid", mv, 0);
      chk("t6_async_tready", tready_s, 0);
      chk("t6_async_grant", gnt, 0);
      chk("t6_async_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk); #1;
      g1 = gq.size(); b0 = bq.size();
      post(4, 2, 8'hFF, 0);
      wait_grants(g1 + 1, 20);
      if (gq.size() > g1) chk("t6_regrant", gq[g1].idx, 4);
      wait_beats(b0 + 2, 20);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/crossbar_arbiter.md
Name: crossbar_arbiter

Overview:
- Output-side arbiter for one crossbar egress port; it serves P_PORTS per-destination queue points, one per ingress.
- Samples each point's transmit request, issues a one-cycle grant pulse in round-robin order, then steers the granted point's AXI-Stream onto the egress port until its tlast handshake.
- A watchdog releases the port if a granted point never delivers data.

Parameters:
P_PORTS, 8, number of requesting points (2..16)
P_TIMEOUT, 1024, max cycles from grant to first granted tvalid before abort
P_IDX_W, 3, clog2(P_PORTS) width of selection index

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_trans_req  in  P_PORTS  per-point transmit request (level, held until granted)
o_trans_grant  out  P_PORTS  one-hot grant, single-cycle pulse
s_axis_tvalid  in  P_PORTS  per-point stream valid
s_axis_tdata  in  64*P_PORTS  per-point data, point k at [64k+63:64k]
s_axis_tlast  in  P_PORTS  per-point last
s_axis_tkeep  in  8*P_PORTS  per-point keep
s_axis_tready  out  P_PORTS  per-point ready; only the selected bit may be 1
m_axis_tvalid  out  1  egress valid
m_axis_tdata  out  64  egress data
m_axis_tlast  out  1  egress last
m_axis_tkeep  out  8  egress keep
m_axis_tuser  out  1  egress user; constant 0
m_axis_tready  in  1  egress ready
o_busy  out  1  high in GRANT/BUSY
o_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async on i_rst_n low, deassert sync to i_clk):
  - State IDLE; rr pointer = 0; selection index = 0; watchdog = 0.
  - All outputs 0: grant, tready, m_axis_*, o_busy, o_timeout.
- IDLE:
  - If any i_trans_req bit is set, select the first set bit searching from rr pointer upward with wrap (P_PORTS-1 wraps to 0).
  - Register the selection index; go to GRANT.
  - Requests are sampled only in IDLE.
- GRANT (one cycle):
  - o_trans_grant = one-hot of the selection index, registered.
  - Go to BUSY and clear the watchdog.
  - The requesting point may still hold its req for 1-2 cycles after the grant. Stale req is ignored because the arbiter is not in IDLE.
- BUSY:
  - Combinational mux, zero latency:
    - m_axis_tvalid/tdata/tlast/tkeep = selected point's signals.
    - s_axis_tready[sel] = m_axis_tready; all other tready bits = 0.
  - Beat accepted = m_axis_tvalid & m_axis_tready.
  - On an accepted beat with tlast: rr pointer = sel+1 (with wrap), go to IDLE next cycle.
  - Watchdog counts while no beat has been seen since grant. If it reaches P_TIMEOUT-1 with no tvalid: pulse o_timeout, set rr pointer = sel+1, go to IDLE. Once any tvalid is seen, the watchdog is frozen.
- Outside BUSY:
  - m_axis_tvalid = 0, all s_axis_tready = 0.
  - Data/keep outputs are don't-care, driven 0.
- Arbitration throughput:
  - Minimum inter-packet gap on egress is 2 cycles (IDLE + GRANT).
  - One packet per grant; no interleaving ever.
- Fairness:
  - rr pointer advances only after a completed or aborted service.
  - A continuously requesting point waits at most P_PORTS-1 packets.
- Simultaneous events:
  - New requests arriving during the tlast-accept cycle are seen in the following IDLE cycle.
  - tlast on the first beat is legal: a 1-beat packet.
- Backpressure:
  - m_axis_tready low holds the state; watchdog unaffected once tvalid is seen.
- Reset mid-packet:
  - Outputs drop to 0 asynchronously and the arbiter restarts at IDLE, rr pointer 0.
  - Partial packet is the downstream's concern.
- Width rules:
  - Watchdog counter is clog2(P_TIMEOUT)+1 bits and saturates.
  - Index arithmetic is modulo P_PORTS. When P_PORTS is not a power of 2, sel+1 wraps explicitly to 0.

Decomposition:
- Shared package crossbar_pkg: AXIS data width 64, keep width 8, dest width 3, default P_PORTS = 8, state encoding constants (IDLE = 0, GRANT = 1, BUSY = 2).
- One sub-module rr_pick: combinational round-robin priority encoder.
  - Inputs: req vector, rr pointer.
  - Outputs: found flag, index.
- FSM, watchdog and mux stay in crossbar_arbiter.

Test Plan:
- Single request: req[2]=1 at t0 → grant[2] pulse at t0+2. Point 2 sends 4 beats, tready=1 → egress sees 4 beats, tlast on 4th with keep from point 2, o_busy falls one cycle later.
- All 8 reqs held high, each point sending 2-beat packets → grants in order 0,1,...,7,0. Egress gap between packets is exactly 2 cycles. No tready to non-selected points.
- Backpressure: m_axis_tready toggled 1,0,0,1 during a 3-beat packet from point 5 → beats not lost or duplicated, s_axis_tready[5] mirrors m_axis_tready, other tready bits stay 0.
- Timeout: P_TIMEOUT=16, req[1] granted, point never asserts tvalid → o_timeout pulses 16 cycles after the grant-cycle count starts. Return to IDLE; next pending req[3] granted next.
- 1-beat packet with tkeep=8'h0F from point 7 → egress tvalid & tlast same cycle, tkeep=8'h0F, rr pointer wraps to 0.
- Async reset asserted mid-packet → m_axis_tvalid, tready and grant go 0 without a clock edge. After release, a single req[4] is granted normally.
